// File: rtl/peridot_board_romarb.sv
`default_nettype none
// ============================================================================
//  Module   : peridot_board_romarb
//  Purpose  : Two-requester arbiter and access sequencer for the board
//             ROM-data byte port. Grants one requester, drives the byte
//             address, waits the fixed ROM read latency and returns the byte
//             with a one-cycle acknowledge.
//  Revision : 1.0 - initial release
// ============================================================================
module peridot_board_romarb #(
  parameter int    ADDR_WIDTH  = 5,
  parameter int    ROM_LATENCY = 2,
  parameter string ARB_MODE    = "ROUNDROBIN"
) (
  input  logic                  clock_sig,
  input  logic                  reset_sig,
  input  logic                  req0_request,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  output logic                  req0_ack,
  output logic [7:0]            req0_data,
  input  logic                  req1_request,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  output logic                  req1_ack,
  output logic [7:0]            req1_data,
  input  logic                  rom_ready,
  output logic [ADDR_WIDTH-1:0] rom_byteaddr,
  input  logic [7:0]            rom_bytedata,
  output logic [1:0]            grant,
  output logic                  busy
);

  // Latency counter is sized for the largest legal latency (16 -> load 15).
  localparam int                   c_CNT_WIDTH = 4;
  localparam logic [c_CNT_WIDTH-1:0] c_CNT_LOAD = c_CNT_WIDTH'(ROM_LATENCY - 1);
  localparam bit                   c_FIXED     = (ARB_MODE == "FIXED");

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t                 r_state;
  logic [c_CNT_WIDTH-1:0] r_cnt;
  logic                   r_last_owner;  // 0 = req0, 1 = req1

  state_t                 w_state_next;
  logic [c_CNT_WIDTH-1:0] w_cnt_next;
  logic                   w_last_owner_next;
  logic                   w_winner;
  logic [ADDR_WIDTH-1:0]  w_addr_next;
  logic [1:0]             w_grant_next;
  logic [7:0]             w_data0_next;
  logic [7:0]             w_data1_next;
  logic                   w_ack0_next;
  logic                   w_ack1_next;

  // State and every output are registered; reset aborts any access in flight.
  always_ff @(posedge clock_sig or posedge reset_sig) begin
    if (reset_sig) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_last_owner <= 1'b1;
      rom_byteaddr <= '0;
      grant        <= 2'b00;
      req0_data    <= 8'h00;
      req1_data    <= 8'h00;
      req0_ack     <= 1'b0;
      req1_ack     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_last_owner <= w_last_owner_next;
      rom_byteaddr <= w_addr_next;
      grant        <= w_grant_next;
      req0_data    <= w_data0_next;
      req1_data    <= w_data1_next;
      req0_ack     <= w_ack0_next;
      req1_ack     <= w_ack1_next;
      busy         <= (w_state_next != S_IDLE);
    end
  end

  // Next-state logic: arbitration in IDLE, latency count in WAIT, and a
  // one-cycle RELEASE that ends the ack pulse and drops the grant.
  always_comb begin
    w_state_next      = r_state;
    w_cnt_next        = r_cnt;
    w_last_owner_next = r_last_owner;
    w_winner          = 1'b0;
    w_addr_next       = rom_byteaddr;
    w_grant_next      = grant;
    w_data0_next      = req0_data;
    w_data1_next      = req1_data;
    w_ack0_next       = 1'b0;
    w_ack1_next       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (rom_ready && (req0_request || req1_request)) begin
          if (req0_request && req1_request) begin
            // Tie: fixed priority to req0, otherwise whoever did not go last.
            w_winner = c_FIXED ? 1'b0 : ~r_last_owner;
          end else begin
            w_winner = req1_request;
          end
          w_addr_next       = w_winner ? req1_addr : req0_addr;
          w_grant_next      = w_winner ? 2'b10 : 2'b01;
          w_last_owner_next = w_winner;
          w_cnt_next        = c_CNT_LOAD;
          w_state_next      = S_WAIT;
        end
      end

      S_WAIT: begin
        if (r_cnt != '0) begin
          w_cnt_next = r_cnt - 1'b1;
        end else begin
          // Owner is taken from the grant, not the live request, so a
          // withdrawn request still completes and only the owner is touched.
          if (grant[1]) begin
            w_data1_next = rom_bytedata;
            w_ack1_next  = 1'b1;
          end else begin
            w_data0_next = rom_bytedata;
            w_ack0_next  = 1'b1;
          end
          w_state_next = S_RELEASE;
        end
      end

      S_RELEASE: begin
        w_grant_next = 2'b00;
        w_state_next = S_IDLE;
      end

      default: begin
        w_grant_next = 2'b00;
        w_state_next = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_peridot_board_romarb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_peridot_board_romarb
//  Purpose  : Directed self-checking bench for peridot_board_romarb, one
//             round-robin instance and one fixed-priority instance, each fed
//             by a ROM model returning addr ^ 0xA5.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_peridot_board_romarb;

  logic       clock_sig = 1'b0;
  logic       reset_sig = 1'b1;
  int         checks = 0;
  int         errors = 0;

  // Round-robin instance
  logic       a_req0 = 1'b0, a_req1 = 1'b0, a_ready = 1'b1;
  logic [4:0] a_addr0 = '0, a_addr1 = '0;
  logic       a_ack0, a_ack1, a_busy;
  logic [7:0] a_data0, a_data1, a_romdata;
  logic [4:0] a_byteaddr;
  logic [1:0] a_grant;

  // Fixed-priority instance
  logic       b_req0 = 1'b0, b_req1 = 1'b0;
  logic [4:0] b_addr0 = '0, b_addr1 = '0;
  logic       b_ack0, b_ack1, b_busy;
  logic [7:0] b_data0, b_data1, b_romdata;
  logic [4:0] b_byteaddr;
  logic [1:0] b_grant;

  always #5 clock_sig = ~clock_sig;

  peridot_board_romarb #(.ADDR_WIDTH(5), .ROM_LATENCY(2), .ARB_MODE("ROUNDROBIN")) dut_a (
    .clock_sig(clock_sig), .reset_sig(reset_sig),
    .req0_request(a_req0), .req0_addr(a_addr0), .req0_ack(a_ack0), .req0_data(a_data0),
    .req1_request(a_req1), .req1_addr(a_addr1), .req1_ack(a_ack1), .req1_data(a_data1),
    .rom_ready(a_ready), .rom_byteaddr(a_byteaddr), .rom_bytedata(a_romdata),
    .grant(a_grant), .busy(a_busy)
  );

  peridot_board_romarb #(.ADDR_WIDTH(5), .ROM_LATENCY(2), .ARB_MODE("FIXED")) dut_b (
    .clock_sig(clock_sig), .reset_sig(reset_sig),
    .req0_request(b_req0), .req0_addr(b_addr0), .req0_ack(b_ack0), .req0_data(b_data0),
    .req1_request(b_req1), .req1_addr(b_addr1), .req1_ack(b_ack1), .req1_data(b_data1),
    .rom_ready(1'b1), .rom_byteaddr(b_byteaddr), .rom_bytedata(b_romdata),
    .grant(b_grant), .busy(b_busy)
  );

  // ROM models: data for the registered address is valid one edge later,
  // so it is ready when the arbiter samples it two edges after the grant.
  always_ff @(posedge clock_sig) begin
    a_romdata <= {3'b000, a_byteaddr} ^ 8'hA5;
    b_romdata <= {3'b000, b_byteaddr} ^ 8'hA5;
  end

  task automatic check_value(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock_sig);
  endtask

  // One access on instance A. Call with the request(s) already set up.
  // mid_drop withdraws the owner's request and drops rom_ready during WAIT.
  task automatic serve_a(input bit owner, input logic [7:0] exp_data,
                         input bit drop0, input bit drop1, input bit mid_drop);
    tick(1);
    check_value("a_grant", 32'(a_grant), owner ? 32'h2 : 32'h1);
    check_value("a_busy", 32'(a_busy), 32'h1);
    check_value("a_byteaddr", 32'(a_byteaddr), owner ? 32'(a_addr1) : 32'(a_addr0));
    if (mid_drop) begin
      if (owner) a_req1 = 1'b0; else a_req0 = 1'b0;
      a_ready = 1'b0;
    end
    tick(1);
    check_value("a_ack_early", 32'({a_ack1, a_ack0}), 32'h0);
    tick(1);
    check_value("a_ack_owner", owner ? 32'(a_ack1) : 32'(a_ack0), 32'h1);
    check_value("a_ack_other", owner ? 32'(a_ack0) : 32'(a_ack1), 32'h0);
    check_value("a_data", owner ? 32'(a_data1) : 32'(a_data0), 32'(exp_data));
    if (drop0) a_req0 = 1'b0;
    if (drop1) a_req1 = 1'b0;
    tick(1);
    check_value("a_ack_end", 32'({a_ack1, a_ack0}), 32'h0);
    check_value("a_grant_end", 32'(a_grant), 32'h0);
    check_value("a_busy_end", 32'(a_busy), 32'h0);
    a_ready = 1'b1;
  endtask

  task automatic serve_b(input bit owner, input logic [7:0] exp_data, input bit drop0, input bit drop1);
    tick(1);
    check_value("b_grant", 32'(b_grant), owner ? 32'h2 : 32'h1);
    tick(2);
    check_value("b_ack", 32'({b_ack1, b_ack0}), owner ? 32'h2 : 32'h1);
    check_value("b_data", owner ? 32'(b_data1) : 32'(b_data0), 32'(exp_data));
    if (drop0) b_req0 = 1'b0;
    if (drop1) b_req1 = 1'b0;
    tick(1);
    check_value("b_ack_end", 32'({b_ack1, b_ack0}), 32'h0);
  endtask

  initial begin
    // Reset values
    tick(2);
    reset_sig = 1'b0;
    tick(2);
    check_value("rst_grant", 32'(a_grant), 32'h0);
    check_value("rst_busy", 32'(a_busy), 32'h0);
    check_value("rst_acks", 32'({a_ack1, a_ack0}), 32'h0);
    check_value("rst_data0", 32'(a_data0), 32'h0);
    check_value("rst_data1", 32'(a_data1), 32'h0);
    check_value("rst_byteaddr", 32'(a_byteaddr), 32'h0);
    check_value("rst_b_grant", 32'(b_grant), 32'h0);

    // Single req0 read: 0x03 ^ 0xA5 = 0xA6
    a_addr0 = 5'h03; a_req0 = 1'b1;
    serve_a(1'b0, 8'hA6, 1'b1, 1'b0, 1'b0);

    // Round-robin tie from reset: req0, req1, req0, req1
    reset_sig = 1'b1; tick(1); reset_sig = 1'b0; tick(1);
    a_addr0 = 5'h01; a_addr1 = 5'h1F; a_req0 = 1'b1; a_req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      serve_a(k[0], k[0] ? 8'hBA : 8'hA4, k == 3, k == 3, 1'b0);
    end
    check_value("rr_data0_hold", 32'(a_data0), 32'hA4);

    // Ready gating: nothing starts while rom_ready is low
    a_ready = 1'b0; a_addr1 = 5'h0A; a_req1 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      check_value("gate_grant", 32'(a_grant), 32'h0);
      check_value("gate_busy", 32'(a_busy), 32'h0);
    end
    a_ready = 1'b1;
    serve_a(1'b1, 8'hAF, 1'b0, 1'b1, 1'b0);

    // Request and rom_ready withdrawn mid-WAIT: access still completes
    a_addr0 = 5'h05; a_req0 = 1'b1;
    serve_a(1'b0, 8'hA0, 1'b0, 1'b0, 1'b1);

    // Reset mid-access: abort with no ack, then a normal access
    a_addr1 = 5'h07; a_req1 = 1'b1;
    tick(1);
    check_value("abort_grant", 32'(a_grant), 32'h2);
    tick(1);
    reset_sig = 1'b1;
    #1;
    check_value("abort_grant_rst", 32'(a_grant), 32'h0);
    check_value("abort_busy", 32'(a_busy), 32'h0);
    check_value("abort_byteaddr", 32'(a_byteaddr), 32'h0);
    check_value("abort_data0", 32'(a_data0), 32'h0);
    check_value("abort_data1", 32'(a_data1), 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick(1);
      check_value("abort_no_ack", 32'({a_ack1, a_ack0}), 32'h0);
    end
    reset_sig = 1'b0;
    serve_a(1'b1, 8'hA2, 1'b0, 1'b1, 1'b0);

    // FIXED mode: req0 keeps winning while held, then req1 is served
    b_addr0 = 5'h02; b_addr1 = 5'h04; b_req0 = 1'b1; b_req1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      serve_b(1'b0, 8'hA7, k == 2, 1'b0);
    end
    serve_b(1'b1, 8'hA1, 1'b0, 1'b1);
    check_value("b_data0_hold", 32'(b_data0), 32'hA7);

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/peridot_board_romarb.md
# peridot_board_romarb

Two-port arbiter and access sequencer for the board ROM-data byte port (`byteaddr`/`bytedata`/`ready`) in the PERIDOT host bridge. It lets the I2C EEPROM emulator and a second requester (host-side register read of ID/UID bytes) share one ROM-data instance. For each request it grants one requester, drives the byte address, waits the fixed ROM read latency, and returns the byte with a one-cycle acknowledge.

## Interface

**Parameters**

- `ADDR_WIDTH`, default 5: byte address width.
- `ROM_LATENCY`, default 2: edges from address registered to `rom_bytedata` valid. Legal range 1..16.
- `ARB_MODE`, default "ROUNDROBIN": set to "FIXED" to give req0 absolute priority. Any other value behaves as "ROUNDROBIN".

**Ports** (reset reset_sig, asynchronous, active-high; clock clock_sig)

- `clock_sig` in 1: clock; all logic is on the rising edge.
- `reset_sig` in 1: asynchronous, active-high reset.
- `req0_request` in 1: level request from the I2C emulator side; held until ack.
- `req0_addr` in ADDR_WIDTH: byte address; stable while request is high.
- `req0_ack` out 1: one-cycle pulse; `req0_data` is valid in this cycle.
- `req0_data` out 8: returned byte; holds its value until the next req0 completion.
- `req1_request`, `req1_addr`, `req1_ack`, `req1_data`: same signals and rules for requester 1.
- `rom_ready` in 1: ROM-data ready (UID loaded); gates the start of any new access.
- `rom_byteaddr` out ADDR_WIDTH: address to the ROM-data block; holds its last value when idle.
- `rom_bytedata` in 8: ROM byte.
- `grant` out 2: one-hot current owner; bit0 = req0. High in WAIT and RELEASE.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation

**Reset values:** state IDLE, `rom_byteaddr`=0, `req0_data`/`req1_data`=0, both acks 0, `grant`=00, `busy`=0, `last_owner`=1 (so req0 wins the first tie), latency counter 0.

**State machine (3 states)**

- **IDLE**
  - Stay if `rom_ready`=0 or no request is high.
  - Otherwise select a winner:
    - Only one request high: that requester wins.
    - Both high, FIXED mode: req0 wins.
    - Both high, ROUNDROBIN mode: the requester ≠ `last_owner` wins.
  - Register the winner's address into `rom_byteaddr`, set `grant`, set `last_owner`, load counter with ROM_LATENCY−1, go to WAIT.
- **WAIT**
  - Counter ≠ 0: decrement.
  - Counter = 0: capture `rom_bytedata` into the owner's data register, assert the owner's ack, go to RELEASE.
- **RELEASE**
  - Deassert ack, clear `grant`, go to IDLE.

**Boundary rules**

- Request withdrawn during WAIT: the access still completes and ack is still pulsed; the requester ignores it. Data register updates.
- `rom_ready` falling during WAIT: no effect; the access completes.
- A request still high in IDLE after its ack is treated as a new request.
- Address changes while a request is pending are sampled only at the grant edge.
- Non-owner data registers and acks are never disturbed.
- Reset mid-access: abort immediately to reset values; no ack is issued.

## Timing

- Request sampled at edge E0 (state IDLE). Owner ack is high for exactly the cycle after edge E0+ROM_LATENCY; data is valid in that same cycle.
- Ack is low after edge E0+ROM_LATENCY+1. The next grant is possible at edge E0+ROM_LATENCY+2.
- Throughput: one byte per ROM_LATENCY+2 cycles.
- A requester must drop its request on the edge where it samples ack high, otherwise it is re-served.
- `busy` rises at E0 and falls at E0+ROM_LATENCY+1.
- No combinational path from any input to any output; all outputs are registered.

## Test plan

- **Reset check:** reset, then idle with no requests → all outputs at reset values; `rom_byteaddr`=0.
- **Single req0 read:** ROM_LATENCY=2; ROM model returns addr^0xA5 with 2-edge latency; req0 addr=0x03 → `req0_ack` one-cycle pulse 2 cycles after grant, `req0_data`=0xA6; `req1_ack` never asserted.
- **Round-robin tie:** both requests held continuously, addr0=0x01, addr1=0x1F → grants alternate req0, req1, req0, ...; each ack carries the correct byte; the spacing between successive acks is 4 cycles.
- **FIXED mode tie:** ARB_MODE="FIXED", both requests held → only req0 is ever served while it stays asserted; req1 is served after req0 drops.
- **Ready gating:** `rom_ready`=0 with req1 high for 10 cycles → no grant and `busy`=0; raise `rom_ready` → grant on the next edge.
- **Disturbances:** drop req0 mid-WAIT → ack still pulses. Assert reset during WAIT → ack never pulses, outputs return to reset values, and the next request completes normally.
